// File: rtl/multi_debouncer_if.sv
// Button-conditioner bus: raw button levels in, debounced levels and
// single-cycle event pulses out. One bit per channel.
interface multi_debouncer_if #(
    parameter int unsigned N = 4
);
    logic [N-1:0] btn_i;
    logic [N-1:0] clean_o;
    logic [N-1:0] press_o;
    logic [N-1:0] release_o;
    logic [N-1:0] repeat_o;

    modport master (
        output btn_i,
        input  clean_o,
        input  press_o,
        input  release_o,
        input  repeat_o
    );

    modport slave (
        input  btn_i,
        output clean_o,
        output press_o,
        output release_o,
        output repeat_o
    );
endinterface

// File: rtl/multi_debouncer.sv
// N-channel button conditioner: 2-FF synchronizer, symmetric press/release
// debounce counter, clean level, registered press/release pulses.
// Optional auto-repeat on held buttons is enabled by defining AUTO_REPEAT_EN;
// without it repeat_o is tied low and no repeat counters exist.
module multi_debouncer #(
    parameter int unsigned N             = 4,
    parameter int unsigned DELAY         = 300000,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000
) (
    input logic              clk,
    input logic              rst_n,
    multi_debouncer_if.slave bus
);
    localparam int unsigned CW = $clog2(DELAY + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DELAY - 1);

    // Reject configurations the counters cannot represent.
    if (N < 1 || DELAY < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("multi_debouncer: N, DELAY, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic [N-1:0]  s1;
    logic [N-1:0]  s2;
    logic [N-1:0]  clean_q;
    logic [N-1:0]  press_q;
    logic [N-1:0]  release_q;
    logic [N-1:0]  fire;
    logic [CW-1:0] cnt [N];

    // A channel commits its new level when s2 has differed from clean for DELAY cycles.
    always_comb begin
        fire = '0;
        for (int unsigned i = 0; i < N; i++) begin
            fire[i] = (s2[i] != clean_q[i]) && (cnt[i] == CNT_LAST);
        end
    end

    // Synchronizer, debounce counters, clean level and edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1        <= '0;
            s2        <= '0;
            clean_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1 <= bus.btn_i;
            s2 <= s1;
            for (int unsigned i = 0; i < N; i++) begin
                press_q[i]   <= fire[i] & s2[i];
                release_q[i] <= fire[i] & ~s2[i];
                if (s2[i] == clean_q[i]) begin
                    cnt[i] <= '0;
                end else if (fire[i]) begin
                    clean_q[i] <= s2[i];
                    cnt[i]     <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign bus.clean_o   = clean_q;
    assign bus.press_o   = press_q;
    assign bus.release_o = release_q;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] REP_FIRST_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] REP_NEXT_LAST  = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rep [N];
    logic [N-1:0]  rep_armed;
    logic [N-1:0]  repeat_q;

    // Auto-repeat: the counter is 0 during the press cycle, so the first pulse
    // lands REPEAT_DELAY cycles after press_o; a pending release (fire while
    // clean is high) clears it so repeat_o never coincides with release_o.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_armed <= '0;
            repeat_q  <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                rep[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (!clean_q[i] || fire[i]) begin
                    rep[i]       <= '0;
                    rep_armed[i] <= 1'b0;
                    repeat_q[i]  <= 1'b0;
                end else if (rep[i] == (rep_armed[i] ? REP_NEXT_LAST : REP_FIRST_LAST)) begin
                    rep[i]       <= '0;
                    rep_armed[i] <= 1'b1;
                    repeat_q[i]  <= 1'b1;
                end else begin
                    rep[i]      <= rep[i] + 1'b1;
                    repeat_q[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.repeat_o = repeat_q;
`else
    assign bus.repeat_o = '0;
`endif

endmodule
